// File: rtl/slot_i2s_transmitter_pkg.sv
// Shared definitions for the slot I2S transmitter.
//   slot_mode_t    : DAC2 (2 channels, one data line) / DAC8 (8 channels, four lines)
//   channels_for() : channel count carried by a slot mode
package slot_i2s_transmitter_pkg;

    localparam int I2S_SLOT_BITS_DEFAULT = 32;
    localparam int I2S_MAX_LINES         = 4;
    localparam int I2S_MAX_CHANNELS      = 2 * I2S_MAX_LINES;

    typedef enum logic {
        SLOT_DAC2 = 1'b0,
        SLOT_DAC8 = 1'b1
    } slot_mode_t;

    function automatic int channels_for(slot_mode_t mode);
        return (mode == SLOT_DAC8) ? 8 : 2;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// Bit/word clock generator for the slot I2S transmitter.
// Ports:
//   clk, reset_n   master clock, async active-low reset
//   enable         run; low holds the divider and bit counter at zero
//   bck, lrck      registered bit clock and word clock
//   bck_fall       strobe: this clk edge is a falling bck edge
//   frame_start    strobe: bit_idx becomes 0 on this clk edge
//   first_cycle    strobe: first enabled cycle (also a frame start)
//   slot_pos_nxt   slot position that bit_idx takes on this edge
//   half_nxt       channel half (0 left, 1 right) that bit_idx takes on this edge
module i2s_clock_gen #(
    parameter int SLOT_BITS    = 32,
    parameter int MCLK_PER_BCK = 4,
    localparam int PW          = $clog2(SLOT_BITS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          bck,
    output logic          lrck,
    output logic          bck_fall,
    output logic          frame_start,
    output logic          first_cycle,
    output logic [PW-1:0] slot_pos_nxt,
    output logic          half_nxt
);
    localparam int DW = $clog2(MCLK_PER_BCK);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(MCLK_PER_BCK - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_BCK / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] BIT_HALF = BW'(SLOT_BITS);

    logic          active;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [BW-1:0] bit_idx, bit_nxt;

    always_comb begin
        div_nxt     = '0;
        bit_nxt     = '0;
        bck_fall    = 1'b0;
        first_cycle = enable && !active;
        if (enable && active) begin
            bck_fall = (div_cnt == DIV_LAST);
            div_nxt  = bck_fall ? '0 : div_cnt + 1'b1;
            bit_nxt  = bit_idx;
            if (bck_fall) begin
                bit_nxt = (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
            end
        end
        frame_start  = first_cycle || (bck_fall && (bit_idx == BIT_LAST));
        half_nxt     = (bit_nxt >= BIT_HALF);
        slot_pos_nxt = half_nxt ? PW'(bit_nxt - BIT_HALF) : PW'(bit_nxt);
    end

    // bck and lrck are registered from the next-state values so they move
    // on the same clk edge as the counters that define them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_idx <= '0;
            bck     <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            active  <= enable;
            div_cnt <= div_nxt;
            bit_idx <= bit_nxt;
            bck     <= (div_nxt >= DIV_HALF);
            lrck    <= half_nxt;
        end
    end

endmodule

// File: rtl/slot_i2s_transmitter.sv
// I2S master transmitter for one DAC slot (2 or 8 channels).
// Ports:
//   clk, reset_n        master clock, async active-low reset
//   enable              run; low returns the block to idle on the next clk
//   chan                0 = DAC2, 1 = DAC8; latched when enable rises
//   in_valid/in_ready   sample stream handshake, in_data in channel order
//   bck, lrck, sdata    serial outputs (line k carries channels 2k / 2k+1)
//   underrun            one-cycle pulse at a frame start that found an incomplete frame
module slot_i2s_transmitter
    import slot_i2s_transmitter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_BITS    = I2S_SLOT_BITS_DEFAULT,
    parameter int MCLK_PER_BCK = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     chan,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SAMPLE_WIDTH-1:0]  in_data,
    output logic                     bck,
    output logic                     lrck,
    output logic [I2S_MAX_LINES-1:0] sdata,
    output logic                     underrun
);
    localparam int PW  = $clog2(SLOT_BITS);
    localparam int CW  = $clog2(I2S_MAX_CHANNELS + 1);
    localparam int IW  = $clog2(I2S_MAX_CHANNELS);
    localparam int BSW = $clog2(SAMPLE_WIDTH + 1);

    logic                    bck_fall, frame_start, first_cycle, half_nxt;
    logic [PW-1:0]           slot_pos_nxt;
    slot_mode_t              mode_r;
    logic [CW-1:0]           count, n_ch;
    logic                    xfer, buf_full;
    logic [BSW-1:0]          bit_sel;
    logic [I2S_MAX_LINES-1:0] sdata_nxt;
    logic [SAMPLE_WIDTH-1:0] cap_buf [I2S_MAX_CHANNELS];
    logic [SAMPLE_WIDTH-1:0] shadow  [I2S_MAX_CHANNELS];

    i2s_clock_gen #(
        .SLOT_BITS    (SLOT_BITS),
        .MCLK_PER_BCK (MCLK_PER_BCK)
    ) u_clock_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .bck          (bck),
        .lrck         (lrck),
        .bck_fall     (bck_fall),
        .frame_start  (frame_start),
        .first_cycle  (first_cycle),
        .slot_pos_nxt (slot_pos_nxt),
        .half_nxt     (half_nxt)
    );

    // In the first enabled cycle the mode is not latched yet, so the pin is used.
    assign n_ch     = CW'(channels_for(first_cycle ? slot_mode_t'(chan) : mode_r));
    assign in_ready = reset_n && enable && (count < n_ch);
    assign xfer     = in_valid && in_ready;
    assign buf_full = (count == n_ch);

    // Slot position 0 is the one-bck I2S delay bit; positions 1..SAMPLE_WIDTH
    // carry the word MSB first; the rest of the slot is zero padding.
    always_comb begin
        sdata_nxt = '0;
        bit_sel   = BSW'(SAMPLE_WIDTH - int'(slot_pos_nxt));
        if (slot_pos_nxt != '0 && int'(slot_pos_nxt) <= SAMPLE_WIDTH) begin
            for (int k = 0; k < I2S_MAX_LINES; k++) begin
                if (k == 0 || mode_r == SLOT_DAC8) begin
                    sdata_nxt[k] = shadow[{k[1:0], half_nxt}][bit_sel];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r   <= SLOT_DAC2;
            count    <= '0;
            underrun <= 1'b0;
            sdata    <= '0;
            for (int i = 0; i < I2S_MAX_CHANNELS; i++) begin
                cap_buf[i] <= '0;
                shadow[i]  <= '0;
            end
        end else if (!enable) begin
            count    <= '0;
            underrun <= 1'b0;
            sdata    <= '0;
            for (int i = 0; i < I2S_MAX_CHANNELS; i++) begin
                cap_buf[i] <= '0;
                shadow[i]  <= '0;
            end
        end else begin
            underrun <= 1'b0;
            if (first_cycle) begin
                mode_r <= slot_mode_t'(chan);
            end
            if (xfer) begin
                cap_buf[count[IW-1:0]] <= in_data;
            end
            // in_ready is low whenever buf_full, so no transfer collides with the copy.
            if (frame_start && buf_full) begin
                count <= '0;
                for (int i = 0; i < I2S_MAX_CHANNELS; i++) begin
                    shadow[i] <= cap_buf[i];
                end
            end else begin
                count <= count + CW'(xfer);
                if (frame_start) begin
                    underrun <= !first_cycle;
                    for (int i = 0; i < I2S_MAX_CHANNELS; i++) begin
                        shadow[i] <= '0;
                    end
                end
            end
            if (bck_fall || first_cycle) begin
                sdata <= sdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_slot_i2s_transmitter.sv
module tb_slot_i2s_transmitter;
    localparam int SW  = 24;
    localparam int SB  = 32;
    localparam int MPB = 4;
    localparam int FRAME_CLK = 2 * SB * MPB;

    typedef logic [7:0][SW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          chan = 1'b0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic          in_ready, bck, lrck, underrun;
    logic [3:0]    sdata;

    int     checks = 0;
    int     errors = 0;
    int     c = -1;
    int     ur_cnt = 0;
    int     frames_rx = 0;
    bit     stream_chk = 1'b0;
    frame_t exp_q[$];

    // receiver state
    logic              prev_bck = 1'b0;
    logic              prev_lr = 1'b1;
    int                pos = 0;
    logic [3:0]        pad = '0;
    logic [3:0][SW-1:0] sh = '0;
    frame_t            rx = '0;
    frame_t            rx_exp;

    always #5 clk = ~clk;

    slot_i2s_transmitter #(
        .SAMPLE_WIDTH (SW),
        .SLOT_BITS    (SB),
        .MCLK_PER_BCK (MPB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .chan     (chan),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .bck      (bck),
        .lrck     (lrck),
        .sdata    (sdata),
        .underrun (underrun)
    );

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_c(input int target);
        int g = 0;
        while (c < target && g < 6000) begin
            @(negedge clk);
            g++;
        end
        chk(64'(c >= target), 64'd1, "wait_timeout");
    endtask

    task automatic send(input logic [SW-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(64'(n < 2000), 64'd1, "send_timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // c = clk edges since the first enabled edge; outputs sampled 1 time unit after each edge.
    always @(posedge clk) begin
        if (!reset_n || !enable) c = -1;
        else c = c + 1;
        #1;
        if (c < 0) begin
            chk({bck, lrck, sdata, underrun, in_ready}, '0, "idle_outputs");
            prev_bck = 1'b0;
            prev_lr  = 1'b1;
            pos      = 0;
            pad      = '0;
        end else begin
            chk(bck, 64'((c % MPB) >= MPB / 2), "bck_wave");
            chk(lrck, 64'(((c / MPB) % (2 * SB)) >= SB), "lrck_wave");
            if (stream_chk) chk(in_ready, 64'((c % FRAME_CLK) < 8), "in_ready_window");
            if (underrun === 1'b1) begin
                ur_cnt++;
                chk(64'(c % FRAME_CLK), 64'd0, "underrun_at_frame_start");
            end
            if (bck && !prev_bck) begin
                if (lrck !== prev_lr) pos = 0;
                else pos++;
                prev_lr = lrck;
                for (int k = 0; k < 4; k++) begin
                    if (pos >= 1 && pos <= SW) sh[k] = {sh[k][SW-2:0], sdata[k]};
                    else pad[k] = pad[k] | sdata[k];
                end
                if (pos == SB - 1) begin
                    for (int k = 0; k < 4; k++) rx[2 * k + int'(lrck)] = sh[k];
                    chk(pad, '0, "padding_bits");
                    pad = '0;
                    if (lrck) begin
                        chk(64'(exp_q.size() != 0), 64'd1, "frame_expected");
                        if (exp_q.size() != 0) begin
                            rx_exp = exp_q.pop_front();
                            for (int ch = 0; ch < 8; ch++)
                                chk(rx[ch], rx_exp[ch], $sformatf("frame%0d_ch%0d", frames_rx, ch));
                        end
                        frames_rx++;
                    end
                end
            end
            prev_bck = bck;
        end
    end

    initial begin
        frame_t f;
        int     r;
        int     g;
        bit     took;

        // reset, then idle with enable low
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        chk({bck, lrck, sdata, in_ready, underrun}, '0, "idle_after_100");

        // DAC2: frame 1 zero, frame 2 data, frame 3 underrun, frame 4 late pair
        f = '0; exp_q.push_back(f);
        chan = 1'b0;
        enable = 1'b1;
        wait_c(2);
        send(24'h800001);
        send(24'h7FFFFF);
        f = '0; f[0] = 24'h800001; f[1] = 24'h7FFFFF; exp_q.push_back(f);
        wait_c(FRAME_CLK + 10);
        send(24'h123456);
        f = '0; exp_q.push_back(f);
        wait_c(2 * FRAME_CLK + 10);
        send(24'hABCDEF);
        f = '0; f[0] = 24'h123456; f[1] = 24'hABCDEF; exp_q.push_back(f);

        // disable at bit_idx 40 of frame 5 (which itself underran)
        wait_c(4 * FRAME_CLK + 40 * MPB + 1);
        chk(lrck, 64'd1, "lrck_before_disable");
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk({bck, lrck, sdata, underrun, in_ready}, '0, "disable_midframe");
        chk(64'(ur_cnt), 64'd2, "dac2_underruns");
        chk(64'(exp_q.size()), 64'd0, "dac2_frames_drained");
        repeat (20) @(negedge clk);

        // DAC8: continuous ramp 1..80 over frames 2..11, chan toggled while running
        f = '0; exp_q.push_back(f);
        for (int j = 2; j <= 11; j++) begin
            f = '0;
            for (int ch = 0; ch < 8; ch++) f[ch] = SW'(8 * (j - 2) + 1 + ch);
            exp_q.push_back(f);
        end
        stream_chk = 1'b1;
        chan = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        r = 1;
        g = 0;
        took = 1'b0;
        in_valid = 1'b1;
        while (c < 11 * FRAME_CLK + 4 && g < 4000) begin
            if (took) r++;
            in_data = SW'(r);
            took = in_ready;
            if (c == 600) chan = 1'b0;
            @(negedge clk);
            g++;
        end
        chk(64'(g < 4000), 64'd1, "stream_timeout");
        stream_chk = 1'b0;
        in_valid = 1'b0;
        chk(64'(ur_cnt), 64'd2, "dac8_no_underrun");
        chk(64'(exp_q.size()), 64'd0, "dac8_frames_drained");
        chk(64'(frames_rx), 64'd15, "frames_received");

        // async reset while running: outputs drop without waiting for a clock
        #1 reset_n = 1'b0;
        #1 chk({bck, lrck, sdata, underrun, in_ready}, '0, "async_reset");
        @(negedge clk);
        enable = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_i2s_transmitter.md
Name: slot_i2s_transmitter

Overview:
- Host-side (FPGA) I2S master transmitter for one DAC slot.
- Accepts audio samples over a valid/ready stream, double-buffers one full frame, and drives bck, lrck and 1 or 4 serial data lines onto the slot's slotdata pins.
- Supports 2-channel (DAC2) and 8-channel (DAC8) slots.
- Emits zero data and flags underrun when the host does not supply a complete frame in time.

Parameters:
- SAMPLE_WIDTH, 24: bits per sample; must be at most SLOT_BITS-1.
- SLOT_BITS, 32: bck periods per channel half-frame; a frame is 2*SLOT_BITS bck periods.
- MCLK_PER_BCK, 4: clk cycles per bck period; must be even and at least 2.

Ports:
- clk  in  1  master clock (slot mclk domain).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  transmitter run; 0 holds the block idle.
- chan  in  1  0 = 2-channel (DAC2), 1 = 8-channel (DAC8); latched on enable 0->1.
- in_valid  in  1  sample available.
- in_ready  out  1  block accepts the sample this cycle.
- in_data  in  SAMPLE_WIDTH  two's-complement sample, supplied in channel order 0..N-1.
- bck  out  1  bit clock.
- lrck  out  1  word clock; 0 = left, 1 = right.
- sdata  out  4  serial data; line k carries channels 2k (left) and 2k+1 (right).
- underrun  out  1  one-cycle pulse at a frame start with an incomplete capture buffer.

Behaviour:
- Reset state (reset_n low, or enable low): bck=0, lrck=0, sdata=0, in_ready=0, underrun=0. The divider, bit index, capture count and shadow buffer are all cleared.
- Channel count: N=2 when the latched chan=0, N=8 when chan=1. chan changes while enabled are ignored. When N=2, sdata[3:1] stay 0.
- Divider: div_cnt counts 0..MCLK_PER_BCK-1 and wraps.
  - bck is registered: 0 when div_cnt < MCLK_PER_BCK/2, otherwise 1.
  - A falling-edge event occurs at the div_cnt wrap to 0.
- Bit index: bit_idx counts 0..2*SLOT_BITS-1 and advances on each falling-edge event, except the first cycle after enable, where bit_idx=0.
  - lrck = (bit_idx >= SLOT_BITS); it changes only with a falling bck.
- Data timing (standard I2S, one-bck delay):
  - Slot position p = bit_idx mod SLOT_BITS.
  - p=0 outputs 0. p=1..SAMPLE_WIDTH outputs word bits MSB..LSB. p > SAMPLE_WIDTH outputs 0.
  - sdata updates only with a falling bck; the receiver samples on a rising bck.
- Capture buffer: N words plus a count.
  - in_ready = enable && (count < N).
  - A transfer (in_valid && in_ready) writes word[count] and increments count.
- Frame start: the cycle in which bit_idx becomes 0, including the first cycle after enable. At this point:
  - If the registered count == N: copy the capture buffer to the shadow buffer, clear count, shadow_valid=1.
  - Otherwise: load zeros into the shadow buffer, keep count, and pulse underrun, except at the first frame start after enable.
  - A sample accepted in the frame-start cycle that completes the buffer does not count for this frame; it is used at the next frame start.
  - in_ready is 0 in the frame-start cycle when count==N, and rises the following cycle after the copy.
- Latency: a frame fully accepted by frame start F appears on the wire during frame F, with the MSB of ch0 at bit_idx=1.
- enable 0 mid-frame: return to the reset state on the next clk. Partial capture is discarded. No underrun pulse.
- Async reset mid-operation: same as enable 0, but immediate.

Decomposition:
- The shared package (structures.sv) gains constants I2S_SLOT_BITS_DEFAULT and I2S_MAX_LINES=4.
- It also gains a function channels_for(SlotMode) that returns 2 or 8.
- One sub-module: i2s_clock_gen.
  - Holds div_cnt and bit_idx.
  - Produces bck, lrck, the falling-edge strobe, frame_start and slot position p.
  - The top level holds the buffers and the shifters.

Test Plan:
- Reset/idle: reset_n=0, then enable=0 for 100 cycles -> bck=lrck=sdata=in_ready=underrun=0 throughout.
- DAC2 basic (MCLK_PER_BCK=4): enable, chan=0; push 0x800001 and 0x7FFFFF before the 2nd frame start.
  - bck period 4 clk; lrck period 256 clk.
  - In frame 2, sdata[0] = 0, 1000...0001, zeros on the left half, then 0, 0111...1111, zeros on the right half.
  - sdata[3:1]=0 throughout.
- DAC8 mapping: chan=1; push ch0..7 = 0x000001..0x000008.
  - Line k shows 2k+1 left and 2k+2 right, with the LSB at bit_idx 24/56.
  - Check against the slot_model's i2s_receiver outputs.
- Underrun: DAC2; supply only one sample before frame start 3 -> one underrun pulse, that frame is all zero.
  - The second sample then completes the buffer and is transmitted at the next frame.
- Backpressure/boundary: hold in_valid=1 continuously -> in_ready drops after N accepts and reasserts exactly 1 cycle after each frame start. No sample is lost or duplicated over 10 frames of a ramp.
- Mid-frame disable: deassert enable at bit_idx=40, re-enable with chan=1.
  - All outputs go 0 next cycle.
  - The new mode takes effect; no underrun pulse at the first frame.
